// File: rtl/puf_word_uart_tx_if.sv
// Handshake/data bundle between the PUF sequencer and the 64-bit word UART transmitter.
interface puf_word_uart_tx_if;
  logic        gosen;
  logic [63:0] rddata;
  logic        txd;
  logic        uartRdy;
  logic        uartdone;

  modport master (output gosen, output rddata, input txd, input uartRdy, input uartdone);
  modport slave  (input gosen, input rddata, output txd, output uartRdy, output uartdone);
endinterface

// File: rtl/puf_word_uart_tx.sv
// Serialises a 64-bit word as eight back-to-back 8N1 bytes, MSB byte first; frame takes 80*CLKS_PER_BIT cycles.
// No backpressure: starts arriving while busy (uartRdy low) are dropped.
module puf_word_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  puf_word_uart_tx_if.slave        bus
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state, w_state;
  logic [63:0] r_shift, w_shift;
  logic [2:0]  r_byte_cnt, w_byte_cnt;
  logic [2:0]  r_bit_cnt, w_bit_cnt;
  logic [15:0] r_baud_cnt, w_baud_cnt;
  logic        r_txd, w_txd;
  logic        r_done, w_done;
  logic        r_gosen_d;
  logic        w_start;
  logic        w_bit_end;
  logic [7:0]  w_cur_byte;

  assign w_start   = bus.gosen & ~r_gosen_d;
  assign w_bit_end = (r_baud_cnt == BAUD_MAX);

  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_byte_cnt = r_byte_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_baud_cnt = r_baud_cnt;
    w_done     = r_done;
    w_txd      = 1'b1;
    w_cur_byte = 8'h00;

    if (r_state != S_IDLE) begin
      w_baud_cnt = w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state    = S_START;
          w_shift    = bus.rddata;
          w_byte_cnt = 3'd0;
          w_bit_cnt  = 3'd0;
          w_baud_cnt = 16'd0;
          w_done     = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) w_state = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_state   = S_STOP;
            w_bit_cnt = 3'd0;
          end else begin
            w_bit_cnt = r_bit_cnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte_cnt == 3'd7) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else begin
            w_state    = S_START;
            w_byte_cnt = r_byte_cnt + 3'd1;
            w_shift    = {r_shift[55:0], 8'h00};
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

    // txd is derived from the next state so the line moves on the same edge as the FSM.
    w_cur_byte = w_shift[63:56];
    case (w_state)
      S_START: w_txd = 1'b0;
      S_DATA:  w_txd = w_cur_byte[w_bit_cnt];
      default: w_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= 64'd0;
      r_byte_cnt <= 3'd0;
      r_bit_cnt  <= 3'd0;
      r_baud_cnt <= 16'd0;
      r_txd      <= 1'b1;
      r_done     <= 1'b0;
      r_gosen_d  <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_byte_cnt <= w_byte_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_baud_cnt <= w_baud_cnt;
      r_txd      <= w_txd;
      r_done     <= w_done;
      r_gosen_d  <= bus.gosen;
    end
  end

  assign bus.txd      = r_txd;
  assign bus.uartRdy  = (r_state == S_IDLE);
  assign bus.uartdone = r_done;

endmodule
